ripple_tap_strobe: RTL

//   Consumes the eight ripple-divider outputs (div2..div256) in the main clk domain.
//   - Synchronises all taps and selects one at run time.
//   - Emits a single-cycle tick on each rising edge of the selected tap.
//   - Counts ticks for downstream LED/pattern logic.
//   - Blanks ticks for a settle window after every tap change, so no spurious edge is reported.

---
 rtl/ripple_tap_strobe_pkg.sv | 22 ++
 rtl/ripple_tap_strobe_if.sv | 35 +++
 rtl/ripple_tap_strobe_tap_sync.sv | 31 +++
 rtl/ripple_tap_strobe.sv | 109 ++++++++++
 4 files changed

// File: rtl/ripple_tap_strobe_pkg.sv
// Shared types and constants for the ripple tap strobe block.
// Build option: RIPPLE_TAP_BOTH_EDGES_EN selects both-edge ticking in edge_hit().
package ripple_pkg;

  localparam int NUM_TAPS  = 8;
  localparam int TAP_SEL_W = 3;

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } state_t;

  // Edge qualifier applied to the synchronised level and its one-cycle-old copy.
  function automatic logic edge_hit(input logic level, input logic prev);
`ifdef RIPPLE_TAP_BOTH_EDGES_EN
    return level ^ prev;
`else
    return level & ~prev;
`endif
  endfunction

endpackage

// File: rtl/ripple_tap_strobe_if.sv
// Bus bundle between the ripple tap strobe and its user.
// master drives taps/select/clear, slave (the strobe block) returns tick status.
interface ripple_tap_strobe_if #(
  parameter int COUNT_W = 16
);

  logic [ripple_pkg::NUM_TAPS-1:0]  taps;
  logic [ripple_pkg::TAP_SEL_W-1:0] tap_sel;
  logic                             count_clr;
  logic                             tick;
  logic                             tap_level;
  logic                             settling;
  logic [COUNT_W-1:0]               tick_count;

  modport master (
    output taps,
    output tap_sel,
    output count_clr,
    input  tick,
    input  tap_level,
    input  settling,
    input  tick_count
  );

  modport slave (
    input  taps,
    input  tap_sel,
    input  count_clr,
    output tick,
    output tap_level,
    output settling,
    output tick_count
  );

endinterface

// File: rtl/ripple_tap_strobe_tap_sync.sv
// One-bit multi-flop synchroniser for a ripple divider tap.
// SYNC_STAGES must be 2..4; q_o is the last stage.
module tap_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw tap into the flop chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  // Synchroniser chain, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ripple_tap_strobe.sv
// Ripple tap strobe: synchronises eight divider taps, selects one, and emits a
// registered one-cycle tick per qualifying edge, with a settle window that
// blanks ticks after every select change, plus a wrapping tick counter.
// Build option: RIPPLE_TAP_BOTH_EDGES_EN ticks on both edges (default: rising only).
module ripple_tap_strobe
  import ripple_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int COUNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  ripple_tap_strobe_if.slave  bus
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [NUM_TAPS-1:0]  sync_s;
  logic                 tap_level_s;

  state_t               state_q,      state_d;
  logic [TAP_SEL_W-1:0] sel_q,        sel_d;
  logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic                 prev_q,       prev_d;
  logic                 tick_q,       tick_d;
  logic [COUNT_W-1:0]   count_q,      count_d;

  // Every tap is synchronised before the mux so the mux never sees raw async data.
  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_sync
    tap_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_tap_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (bus.taps[i]),
      .q_o   (sync_s[i])
    );
  end

  assign tap_level_s = sync_s[sel_q];

  // Next-state logic: a select change always restarts the settle window and
  // suppresses any edge seen on that same cycle.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    settle_cnt_d = settle_cnt_q;
    prev_d       = tap_level_s;
    tick_d       = 1'b0;
    if (bus.tap_sel != sel_q) begin
      sel_d        = bus.tap_sel;
      settle_cnt_d = SETTLE_LOAD;
      state_d      = SETTLE;
    end else begin
      case (state_q)
        SETTLE: begin
          if (settle_cnt_q == '0) begin
            state_d = RUN;
          end else begin
            settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
          end
        end
        RUN: begin
          tick_d = edge_hit(tap_level_s, prev_q);
        end
        default: begin
          state_d      = SETTLE;
          settle_cnt_d = SETTLE_LOAD;
        end
      endcase
    end
  end

  // Tick counter works on the registered tick so a clear never drops a tick.
  always_comb begin
    if (bus.count_clr) begin
      count_d = COUNT_W'(tick_q);
    end else begin
      count_d = count_q + COUNT_W'(tick_q);
    end
  end

  // State, select, edge history, tick and counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= SETTLE;
      sel_q        <= '0;
      settle_cnt_q <= SETTLE_LOAD;
      prev_q       <= 1'b0;
      tick_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      settle_cnt_q <= settle_cnt_d;
      prev_q       <= prev_d;
      tick_q       <= tick_d;
      count_q      <= count_d;
    end
  end

  assign bus.tick       = tick_q;
  assign bus.tap_level  = tap_level_s;
  assign bus.settling   = (state_q == SETTLE);
  assign bus.tick_count = count_q;

endmodule
